// File: rtl/ula_pkg.sv
// ula_pkg: shared definitions for the ula operation sequencer.
// Op encodings, sequencer state enum, instruction field positions.
package ula_pkg;

  localparam logic [2:0] ULA_OP_ADD = 3'b000;
  localparam logic [2:0] ULA_OP_SUB = 3'b001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  // Instruction word field positions
  localparam int INSTR_OP_LSB   = 0;
  localparam int INSTR_RD_LSB   = 3;
  localparam int INSTR_RS1_LSB  = 6;
  localparam int INSTR_RS2_LSB  = 9;
  localparam int INSTR_IMM_LSB  = 12;
  localparam int INSTR_IMM_MSB  = 27;
  localparam int INSTR_USE_IMM  = 28;

  // Only add and sub are executed; everything else raises err
  function automatic logic op_legal(input logic [2:0] op);
    return (op == ULA_OP_ADD) || (op == ULA_OP_SUB);
  endfunction

endpackage

// File: rtl/ula_regfile.sv
// ula_regfile: 8x32 register file, R0 hard-wired to zero.
// Two operand read ports, one debug read port, WB write port plus a
// load write port; on an index collision the WB write wins.
module ula_regfile
  import ula_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  rs1_addr,
  output logic [31:0] rs1_data,
  input  logic [2:0]  rs2_addr,
  output logic [31:0] rs2_data,
  input  logic [2:0]  dbg_addr,
  output logic [31:0] dbg_data,
  input  logic        wb_we,
  input  logic [2:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        load_en,
  input  logic [2:0]  load_addr,
  input  logic [31:0] load_data
);

  logic [31:0] regs [8];

  // Per-register update: WB has priority over load; index 0 is never written
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < 8; i++) begin
        if (wb_we && (wb_addr == 3'(i)))
          regs[i] <= wb_data;
        else if (load_en && (load_addr == 3'(i)))
          regs[i] <= load_data;
      end
    end
  end

  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/ula_seq.sv
// ula_seq: initiator side of the ula ALU interface.
// Accepts instruction words, reads operands from ula_regfile, drives the
// external combinational ula, captures its result and writes it back.
// Optional feature: define ULA_SEQ_IMM_EN to enable the sign-extended
// imm16 operand selected by the use_imm bit.
module ula_seq
  import ula_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        load_en,
  input  logic [2:0]  load_addr,
  input  logic [31:0] load_data,
  input  logic [2:0]  dbg_addr,
  output logic [31:0] dbg_data,
  output logic [31:0] alu_operand1,
  output logic [31:0] alu_operand2,
  output logic [2:0]  alu_operation,
  input  logic [31:0] alu_result,
  output logic        wb_valid,
  output logic [2:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err
);

  state_t      state_reg;
  logic [2:0]  rd_reg;
  logic [31:0] result_reg;

  logic [2:0]  f_op;
  logic [2:0]  f_rd;
  logic [2:0]  f_rs1;
  logic [2:0]  f_rs2;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] op2_sel;
  logic        accept;

  assign f_op  = in_instr[INSTR_OP_LSB  +: 3];
  assign f_rd  = in_instr[INSTR_RD_LSB  +: 3];
  assign f_rs1 = in_instr[INSTR_RS1_LSB +: 3];
  assign f_rs2 = in_instr[INSTR_RS2_LSB +: 3];

`ifdef ULA_SEQ_IMM_EN
  logic [31:0] imm_sext;
  logic        unused_instr_bits;
  assign imm_sext = {{16{in_instr[INSTR_IMM_MSB]}}, in_instr[INSTR_IMM_MSB:INSTR_IMM_LSB]};
  assign op2_sel  = in_instr[INSTR_USE_IMM] ? imm_sext : rs2_data;
  assign unused_instr_bits = ^in_instr[31:29];
`else
  logic unused_instr_bits;
  assign op2_sel = rs2_data;
  assign unused_instr_bits = ^in_instr[31:12];
`endif

  // Loads block accept so a preload never races the operand read
  assign in_ready = (state_reg == IDLE) && !load_en;
  assign accept   = in_valid && in_ready;

  assign wb_rd   = rd_reg;
  assign wb_data = result_reg;

  ula_regfile u_regfile (
    .clk       (clk),
    .reset     (reset),
    .rs1_addr  (f_rs1),
    .rs1_data  (rs1_data),
    .rs2_addr  (f_rs2),
    .rs2_data  (rs2_data),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .wb_we     (wb_valid),
    .wb_addr   (rd_reg),
    .wb_data   (result_reg),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  // Sequencer FSM: IDLE -> EXEC -> WB, all outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      alu_operand1  <= '0;
      alu_operand2  <= '0;
      alu_operation <= ULA_OP_ADD;
      rd_reg        <= '0;
      result_reg    <= '0;
      wb_valid      <= 1'b0;
      err           <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      err      <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            alu_operand1  <= rs1_data;
            alu_operand2  <= op2_sel;
            alu_operation <= f_op;
            rd_reg        <= f_rd;
            err           <= !op_legal(f_op);
            state_reg     <= EXEC;
          end
        end
        EXEC: begin
          if (op_legal(alu_operation)) begin
            result_reg <= alu_result;
            wb_valid   <= 1'b1;
          end
          state_reg <= WB;
        end
        WB: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: directed self-checking bench for ula_seq with a behavioural
// model of the external combinational ula.
`timescale 1ns/1ps
module tb_ula_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        load_en;
  logic [2:0]  load_addr;
  logic [31:0] load_data;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [31:0] alu_operand1;
  logic [31:0] alu_operand2;
  logic [2:0]  alu_operation;
  logic [31:0] alu_result;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int acc_cyc;
  int acc1;
  int wb_cyc;
  logic [31:0] rv;

  ula_seq dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .load_en       (load_en),
    .load_addr     (load_addr),
    .load_data     (load_data),
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data),
    .alu_operand1  (alu_operand1),
    .alu_operand2  (alu_operand2),
    .alu_operation (alu_operation),
    .alu_result    (alu_result),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .err           (err)
  );

  // External ula model: add / sub, anything else yields zero
  assign alu_result = (alu_operation == 3'b000) ? alu_operand1 + alu_operand2 :
                      (alu_operation == 3'b001) ? alu_operand1 - alu_operand2 : 32'h0;

  always #5 clk = ~clk;

  // Edge counter used for latency checks
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%08h", tag, got);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2);
    return {20'h0, rs2, rs1, rd, op};
  endfunction

  task automatic load(input logic [2:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic rd_dbg(input logic [2:0] a, output logic [31:0] d);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  // Present a word, wait for in_ready (bounded), return at the negedge after accept
  task automatic issue(input logic [31:0] w);
    int n;
    n = 0;
    in_instr = w;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", {31'h0, in_ready}, 32'h1);
      in_valid = 1'b0;
    end else begin
      @(negedge clk);
      acc_cyc = cyc;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_wb();
    int n;
    n = 0;
    while (!wb_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!wb_valid) check("wb_valid_timeout", {31'h0, wb_valid}, 32'h1);
    wb_cyc = cyc;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0; dbg_addr = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_op1", alu_operand1, 32'h0);
    check("rst_op2", alu_operand2, 32'h0);
    check("rst_wb_data", wb_data, 32'h0);

    // Add: 5 + 7 into R3
    load(3'd1, 32'd5);
    load(3'd2, 32'd7);
    issue(mk(3'b000, 3'd3, 3'd1, 3'd2));
    check("add_op1", alu_operand1, 32'd5);
    check("add_op2", alu_operand2, 32'd7);
    check("add_err", {31'h0, err}, 32'h0);
    check("add_ready_exec", {31'h0, in_ready}, 32'h0);
    @(negedge clk);
    check("add_wb_valid", {31'h0, wb_valid}, 32'h1);
    check("add_wb_lat", 32'(cyc - acc_cyc), 32'd1);
    check("add_wb_rd", {29'h0, wb_rd}, 32'd3);
    check("add_wb_data", wb_data, 32'd12);
    @(negedge clk);
    check("add_wb_pulse", {31'h0, wb_valid}, 32'h0);
    check("add_ready_back", {31'h0, in_ready}, 32'h1);
    rd_dbg(3'd3, rv);
    check("add_r3", rv, 32'd12);

    // Sub wrap: 0 - 1 into R4
    load(3'd1, 32'd0);
    load(3'd2, 32'd1);
    issue(mk(3'b001, 3'd4, 3'd1, 3'd2));
    @(negedge clk);
    check("sub_wb_data", wb_data, 32'hFFFF_FFFF);
    @(negedge clk);
    rd_dbg(3'd4, rv);
    check("sub_r4", rv, 32'hFFFF_FFFF);

    // Dependent chain: R3 = R1 + R2 (12), then R5 = R3 + R3 (24)
    load(3'd1, 32'd5);
    load(3'd2, 32'd7);
    issue(mk(3'b000, 3'd3, 3'd1, 3'd2));
    acc1 = acc_cyc;
    issue(mk(3'b000, 3'd5, 3'd3, 3'd3));
    check("chain_accept_gap", 32'(acc_cyc - acc1), 32'd3);
    wait_wb();
    check("chain_wb_lat", 32'(wb_cyc - acc1), 32'd4);
    check("chain_wb_data", wb_data, 32'd24);
    @(negedge clk);
    rd_dbg(3'd5, rv);
    check("chain_r5", rv, 32'd24);

    // Illegal op into R6
    load(3'd6, 32'h55);
    issue(mk(3'b010, 3'd6, 3'd1, 3'd2));
    check("ill_err", {31'h0, err}, 32'h1);
    @(negedge clk);
    check("ill_err_pulse", {31'h0, err}, 32'h0);
    check("ill_no_wb", {31'h0, wb_valid}, 32'h0);
    @(negedge clk);
    check("ill_no_wb2", {31'h0, wb_valid}, 32'h0);
    rd_dbg(3'd6, rv);
    check("ill_r6", rv, 32'h55);

    // Add into R0: wb pulses, R0 stays zero
    issue(mk(3'b000, 3'd0, 3'd1, 3'd2));
    @(negedge clk);
    check("r0_wb_valid", {31'h0, wb_valid}, 32'h1);
    check("r0_wb_rd", {29'h0, wb_rd}, 32'd0);
    check("r0_wb_data", wb_data, 32'd12);
    @(negedge clk);
    rd_dbg(3'd0, rv);
    check("r0_reads_zero", rv, 32'h0);

    // Immediate: R1=10, imm16=0xFFFE (-2), rs2=R2=3
    load(3'd1, 32'd10);
    load(3'd2, 32'd3);
    issue(mk(3'b000, 3'd7, 3'd1, 3'd2) | (32'hFFFE << 12) | (32'h1 << 28));
    @(negedge clk);
`ifdef ULA_SEQ_IMM_EN
    check("imm_wb_data", wb_data, 32'd8);
`else
    check("imm_wb_data", wb_data, 32'd13);
`endif
    @(negedge clk);

    // Collision: load to rd during WB cycle, WB value kept (10 + 3)
    issue(mk(3'b000, 3'd3, 3'd1, 3'd2));
    @(negedge clk);
    check("coll_wb_valid", {31'h0, wb_valid}, 32'h1);
    load(3'd3, 32'hDEAD);
    rd_dbg(3'd3, rv);
    check("coll_r3_wb_wins", rv, 32'd13);

    // Load to a different index in the WB cycle: both writes land
    issue(mk(3'b001, 3'd4, 3'd1, 3'd2));
    @(negedge clk);
    load(3'd6, 32'h77);
    rd_dbg(3'd4, rv);
    check("dual_r4", rv, 32'd7);
    rd_dbg(3'd6, rv);
    check("dual_r6", rv, 32'h77);

    // Reset asserted during EXEC
    issue(mk(3'b000, 3'd5, 3'd1, 3'd2));
    reset = 1'b1;
    #1;
    check("rst_exec_wb", {31'h0, wb_valid}, 32'h0);
    @(negedge clk);
    check("rst_hold_wb", {31'h0, wb_valid}, 32'h0);
    check("rst_hold_err", {31'h0, err}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_rel_ready", {31'h0, in_ready}, 32'h1);
    check("rst_rel_wb", {31'h0, wb_valid}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      rd_dbg(3'(i), rv);
      check($sformatf("rst_r%0d", i), rv, 32'h0);
    end
    @(negedge clk);
    check("rst_late_wb", {31'h0, wb_valid}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
